// File: rtl/csr_access_arbiter.sv
// Two-requester CSR access arbiter: grants one read-modify-write sequence at a time
// against a CSR file with a combinational read port and a single-cycle write port.
module csr_access_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0Valid,
    output logic        req0Ready,
    input  logic [11:0] req0Addr,
    input  logic [1:0]  req0Op,
    input  logic [31:0] req0Operand,
    output logic        resp0Valid,
    output logic [31:0] resp0ReadValue,
    output logic        resp0Illegal,
    input  logic        req1Valid,
    output logic        req1Ready,
    input  logic [11:0] req1Addr,
    input  logic [1:0]  req1Op,
    input  logic [31:0] req1Operand,
    output logic        resp1Valid,
    output logic [31:0] resp1ReadValue,
    output logic        resp1Illegal,
    output logic [11:0] csrReadAddr,
    output logic        csrReadEnable,
    input  logic [31:0] csrReadValue,
    input  logic        csrReadIllegal,
    output logic [11:0] csrWriteAddr,
    output logic [31:0] csrWriteValue,
    output logic        csrWriteEnable,
    input  logic        trapPending
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t      stateR;
    state_t      stateNext;
    logic        prioR;
    logic        idR;
    logic [11:0] addrR;
    logic [1:0]  opR;
    logic [31:0] operandR;
    logic [31:0] oldR;
    logic        illegalR;
    logic [11:0] wrAddrR;
    logic [31:0] wrValueR;
    logic        rdEnR;
    logic        wrEnR;
    logic        resp0R;
    logic        resp1R;
    logic        grant0;
    logic        grant1;
    logic        skipWrite;

    function automatic logic [31:0] calcWriteValue(
        input logic [1:0]  op,
        input logic [31:0] oldValue,
        input logic [31:0] operand
    );
        logic [31:0] result;
        case (op)
            OP_WRITE: result = operand;
            OP_SET:   result = oldValue | operand;
            OP_CLEAR: result = oldValue & ~operand;
            default:  result = oldValue;
        endcase
        return result;
    endfunction

    // Next-state decode and arbitration; ready is only ever raised in IDLE.
    always_comb begin
        stateNext = stateR;
        grant0    = 1'b0;
        grant1    = 1'b0;
        skipWrite = 1'b0;
        case (stateR)
            IDLE: begin
                if (!trapPending && (req0Valid || req1Valid)) begin
                    if (req0Valid && req1Valid) begin
                        if ((ROUND_ROBIN != 0) && prioR) begin
                            grant1 = 1'b1;
                        end else begin
                            grant0 = 1'b1;
                        end
                    end else if (req0Valid) begin
                        grant0 = 1'b1;
                    end else begin
                        grant1 = 1'b1;
                    end
                    stateNext = READ;
                end else begin
                    stateNext = IDLE;
                end
            end
            READ: begin
                // Read-only ops, faulting reads and no-op set/clear skip the write port.
                skipWrite = csrReadIllegal || (opR == OP_READ) ||
                            (((opR == OP_SET) || (opR == OP_CLEAR)) && (operandR == 32'd0));
                if (skipWrite) begin
                    stateNext = RESP;
                end else begin
                    stateNext = WRITE;
                end
            end
            WRITE:   stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State, request latch, captured CSR data and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateR   <= IDLE;
            prioR    <= 1'b0;
            idR      <= 1'b0;
            addrR    <= 12'd0;
            opR      <= 2'b00;
            operandR <= 32'd0;
            oldR     <= 32'd0;
            illegalR <= 1'b0;
            wrAddrR  <= 12'd0;
            wrValueR <= 32'd0;
            rdEnR    <= 1'b0;
            wrEnR    <= 1'b0;
            resp0R   <= 1'b0;
            resp1R   <= 1'b0;
        end else begin
            stateR <= stateNext;
            rdEnR  <= (stateNext == READ);
            wrEnR  <= (stateNext == WRITE);
            resp0R <= (stateNext == RESP) && !idR;
            resp1R <= (stateNext == RESP) && idR;
            if (grant0 || grant1) begin
                idR      <= grant1;
                addrR    <= grant1 ? req1Addr : req0Addr;
                opR      <= grant1 ? req1Op : req0Op;
                operandR <= grant1 ? req1Operand : req0Operand;
            end
            if (stateR == READ) begin
                oldR     <= csrReadValue;
                illegalR <= csrReadIllegal;
            end
            if ((stateR == READ) && (stateNext == WRITE)) begin
                wrAddrR  <= addrR;
                wrValueR <= calcWriteValue(opR, csrReadValue, operandR);
            end
            if ((stateR == RESP) && (ROUND_ROBIN != 0)) begin
                prioR <= ~idR;
            end
        end
    end

    assign req0Ready      = grant0;
    assign req1Ready      = grant1;
    assign csrReadEnable  = rdEnR;
    assign csrReadAddr    = addrR;
    assign csrWriteEnable = wrEnR;
    assign csrWriteAddr   = wrAddrR;
    assign csrWriteValue  = wrValueR;
    assign resp0Valid     = resp0R;
    assign resp1Valid     = resp1R;
    assign resp0ReadValue = oldR;
    assign resp1ReadValue = oldR;
    assign resp0Illegal   = illegalR;
    assign resp1Illegal   = illegalR;

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Directed self-checking bench for csr_access_arbiter; a second instance with
// fixed priority runs in lockstep for the contention scenario.
module tb_csr_access_arbiter;

    logic        clk;
    logic        rst;
    logic        req0Valid, req1Valid;
    logic [11:0] req0Addr, req1Addr;
    logic [1:0]  req0Op, req1Op;
    logic [31:0] req0Operand, req1Operand;
    logic [31:0] csrReadValue;
    logic        csrReadIllegal;
    logic        trapPending;

    logic        req0Ready, req1Ready, resp0Valid, resp1Valid, resp0Illegal, resp1Illegal;
    logic [31:0] resp0ReadValue, resp1ReadValue, csrWriteValue;
    logic [11:0] csrReadAddr, csrWriteAddr;
    logic        csrReadEnable, csrWriteEnable;

    logic        bReq0Ready, bReq1Ready, bResp0Valid, bResp1Valid, bResp0Illegal, bResp1Illegal;
    logic [31:0] bResp0ReadValue, bResp1ReadValue, bCsrWriteValue;
    logic [11:0] bCsrReadAddr, bCsrWriteAddr;
    logic        bCsrReadEnable, bCsrWriteEnable;

    int checkCount = 0;
    int errCount   = 0;

    csr_access_arbiter #(.ROUND_ROBIN(1)) dut (
        .clk(clk), .rst(rst),
        .req0Valid(req0Valid), .req0Ready(req0Ready), .req0Addr(req0Addr),
        .req0Op(req0Op), .req0Operand(req0Operand),
        .resp0Valid(resp0Valid), .resp0ReadValue(resp0ReadValue), .resp0Illegal(resp0Illegal),
        .req1Valid(req1Valid), .req1Ready(req1Ready), .req1Addr(req1Addr),
        .req1Op(req1Op), .req1Operand(req1Operand),
        .resp1Valid(resp1Valid), .resp1ReadValue(resp1ReadValue), .resp1Illegal(resp1Illegal),
        .csrReadAddr(csrReadAddr), .csrReadEnable(csrReadEnable),
        .csrReadValue(csrReadValue), .csrReadIllegal(csrReadIllegal),
        .csrWriteAddr(csrWriteAddr), .csrWriteValue(csrWriteValue),
        .csrWriteEnable(csrWriteEnable), .trapPending(trapPending)
    );

    csr_access_arbiter #(.ROUND_ROBIN(0)) dutFixed (
        .clk(clk), .rst(rst),
        .req0Valid(req0Valid), .req0Ready(bReq0Ready), .req0Addr(req0Addr),
        .req0Op(req0Op), .req0Operand(req0Operand),
        .resp0Valid(bResp0Valid), .resp0ReadValue(bResp0ReadValue), .resp0Illegal(bResp0Illegal),
        .req1Valid(req1Valid), .req1Ready(bReq1Ready), .req1Addr(req1Addr),
        .req1Op(req1Op), .req1Operand(req1Operand),
        .resp1Valid(bResp1Valid), .resp1ReadValue(bResp1ReadValue), .resp1Illegal(bResp1Illegal),
        .csrReadAddr(bCsrReadAddr), .csrReadEnable(bCsrReadEnable),
        .csrReadValue(csrReadValue), .csrReadIllegal(csrReadIllegal),
        .csrWriteAddr(bCsrWriteAddr), .csrWriteValue(bCsrWriteValue),
        .csrWriteEnable(bCsrWriteEnable), .trapPending(trapPending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One uncontended request; expected values supplied by the caller.
    task automatic doTxn(input string name, input logic id, input logic [1:0] op,
                         input logic [11:0] addr, input logic [31:0] operand,
                         input logic [31:0] oldVal, input logic illegal,
                         input logic expWrite, input logic [31:0] expWrVal);
        if (id) begin
            req1Valid = 1'b1; req1Op = op; req1Addr = addr; req1Operand = operand;
        end else begin
            req0Valid = 1'b1; req0Op = op; req0Addr = addr; req0Operand = operand;
        end
        csrReadValue   = oldVal;
        csrReadIllegal = illegal;
        #1;
        checkEq({name, ".ready"}, {30'd0, req1Ready, req0Ready}, id ? 32'd2 : 32'd1);
        nextCycle();
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        #1;
        checkEq({name, ".readEn"}, {31'd0, csrReadEnable}, 32'd1);
        checkEq({name, ".readAddr"}, {20'd0, csrReadAddr}, {20'd0, addr});
        checkEq({name, ".wrEnInRead"}, {31'd0, csrWriteEnable}, 32'd0);
        nextCycle();
        if (expWrite) begin
            checkEq({name, ".wrEn"}, {31'd0, csrWriteEnable}, 32'd1);
            checkEq({name, ".wrAddr"}, {20'd0, csrWriteAddr}, {20'd0, addr});
            checkEq({name, ".wrValue"}, csrWriteValue, expWrVal);
            checkEq({name, ".respEarly"}, {30'd0, resp1Valid, resp0Valid}, 32'd0);
            nextCycle();
        end
        checkEq({name, ".respValid"}, {30'd0, resp1Valid, resp0Valid}, id ? 32'd2 : 32'd1);
        checkEq({name, ".respValue"}, id ? resp1ReadValue : resp0ReadValue, oldVal);
        checkEq({name, ".respIllegal"}, {31'd0, id ? resp1Illegal : resp0Illegal}, {31'd0, illegal});
        checkEq({name, ".wrEnInResp"}, {31'd0, csrWriteEnable}, 32'd0);
        csrReadIllegal = 1'b0;
        nextCycle();
        checkEq({name, ".respDone"}, {30'd0, resp1Valid, resp0Valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req0Valid = 1'b0; req1Valid = 1'b0;
        req0Addr = 12'd0; req1Addr = 12'd0;
        req0Op = 2'b00; req1Op = 2'b00;
        req0Operand = 32'd0; req1Operand = 32'd0;
        csrReadValue = 32'd0; csrReadIllegal = 1'b0; trapPending = 1'b0;
        #2;
        checkEq("reset.enables", {28'd0, csrReadEnable, csrWriteEnable, resp0Valid, resp1Valid}, 32'd0);
        checkEq("reset.readAddr", {20'd0, csrReadAddr}, 32'd0);
        checkEq("reset.writeValue", csrWriteValue, 32'd0);
        checkEq("reset.respValue", resp0ReadValue, 32'd0);
        nextCycle();
        nextCycle();
        rst = 1'b0;

        doTxn("read",     1'b0, 2'b00, 12'h300, 32'd0,        32'h0000_1800, 1'b0, 1'b0, 32'd0);
        doTxn("set",      1'b1, 2'b10, 12'h344, 32'h0000_0008, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0009);
        doTxn("clear",    1'b0, 2'b11, 12'h304, 32'h0000_0003, 32'h0000_000F, 1'b0, 1'b1, 32'h0000_000C);
        doTxn("write",    1'b1, 2'b01, 12'h340, 32'hDEAD_BEEF, 32'h0000_0005, 1'b0, 1'b1, 32'hDEAD_BEEF);
        doTxn("setZero",  1'b0, 2'b10, 12'h305, 32'd0,        32'h1234_5678, 1'b0, 1'b0, 32'd0);
        doTxn("illegal",  1'b0, 2'b01, 12'hFFF, 32'h0000_00AA, 32'h0000_0000, 1'b1, 1'b0, 32'd0);
        doTxn("clearAll", 1'b1, 2'b11, 12'h300, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b1, 32'h0000_0000);

        // Trap holds off the grant; in-flight sequence ignores it.
        trapPending = 1'b1;
        req0Valid = 1'b1; req0Op = 2'b00; req0Addr = 12'h341; csrReadValue = 32'h0000_0042;
        #1;
        checkEq("trap.noReady", {31'd0, req0Ready}, 32'd0);
        nextCycle();
        checkEq("trap.stillIdle", {30'd0, req0Ready, csrReadEnable}, 32'd0);
        trapPending = 1'b0;
        #1;
        checkEq("trap.readyAfter", {31'd0, req0Ready}, 32'd1);
        nextCycle();
        req0Valid = 1'b0;
        trapPending = 1'b1;
        #1;
        checkEq("trap.readEn", {31'd0, csrReadEnable}, 32'd1);
        nextCycle();
        checkEq("trap.resp", {31'd0, resp0Valid}, 32'd1);
        checkEq("trap.respValue", resp0ReadValue, 32'h0000_0042);
        trapPending = 1'b0;
        nextCycle();

        // Reset in WRITE aborts the sequence.
        req0Valid = 1'b1; req0Op = 2'b01; req0Addr = 12'h342; req0Operand = 32'h0000_0077;
        csrReadValue = 32'h0000_0011;
        #1;
        checkEq("abort.ready", {31'd0, req0Ready}, 32'd1);
        nextCycle();
        req0Valid = 1'b0;
        nextCycle();
        checkEq("abort.inWrite", {31'd0, csrWriteEnable}, 32'd1);
        rst = 1'b1;
        #1;
        checkEq("abort.wrEnDrops", {31'd0, csrWriteEnable}, 32'd0);
        checkEq("abort.writeValue", csrWriteValue, 32'd0);
        nextCycle();
        rst = 1'b0;
        #1;
        checkEq("abort.noResp", {29'd0, resp1Valid, resp0Valid, csrReadEnable}, 32'd0);
        nextCycle();
        checkEq("abort.noResp2", {29'd0, resp1Valid, resp0Valid, csrWriteEnable}, 32'd0);

        // Contention: round-robin alternates starting from requester 0; fixed priority keeps 0.
        req0Valid = 1'b1; req0Op = 2'b00; req0Addr = 12'h300;
        req1Valid = 1'b1; req1Op = 2'b00; req1Addr = 12'h301;
        csrReadValue = 32'h0000_0001;
        for (int g = 0; g < 4; g++) begin
            #1;
            checkEq($sformatf("rr.grant%0d", g), {30'd0, req1Ready, req0Ready},
                    (g % 2 == 0) ? 32'd1 : 32'd2);
            checkEq($sformatf("fixed.grant%0d", g), {30'd0, bReq1Ready, bReq0Ready}, 32'd1);
            nextCycle();
            checkEq($sformatf("rr.busy%0d", g), {30'd0, req1Ready, req0Ready}, 32'd0);
            nextCycle();
            checkEq($sformatf("rr.resp%0d", g), {30'd0, resp1Valid, resp0Valid},
                    (g % 2 == 0) ? 32'd1 : 32'd2);
            checkEq($sformatf("fixed.resp%0d", g), {30'd0, bResp1Valid, bResp0Valid}, 32'd1);
            nextCycle();
        end
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
